// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide_add_seq slice-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wide_add_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default width of the single adder slice reused every cycle.
  localparam int SLICE_LEN_DEF = 8;

  // Slice index width; a one-slice configuration still needs a 1-bit index.
  function automatic int idx_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/adder_p.sv
// Combinational DATA_LEN-bit adder with carry-in, carry-out and signed overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b (operands), cin (carry-in), sum, cout (carry out of MSB),
//        overflow (two's-complement overflow of a + b + cin).
module adder_p #(
  parameter int DATA_LEN = 8
) (
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  logic                cin,
  output logic                cout,
  output logic [DATA_LEN-1:0] sum,
  output logic                overflow
);

  logic [DATA_LEN:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DATA_LEN{1'b0}}, cin};
  assign sum  = full[DATA_LEN-1:0];
  assign cout = full[DATA_LEN];

  // Overflow when both operands share a sign that the result does not.
  assign overflow = (a[DATA_LEN-1] == b[DATA_LEN-1]) &&
                    (sum[DATA_LEN-1] != a[DATA_LEN-1]);

endmodule

// File: rtl/wide_add_seq.sv
// Slice-serial DATA_LEN-bit add/subtract using one SLICE_LEN-bit adder_p, LSB slice first.
// Latency: NUM_SLICES cycles from accept edge to out_valid; one op per NUM_SLICES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_a, in_b, in_cin, in_sub;
//        out_valid/out_ready with out_sum, out_cout (1 = no borrow on subtract), out_overflow.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int SLICE_LEN = SLICE_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_sum,
  output logic                out_cout,
  output logic                out_overflow
);

  localparam int NUM_SLICES = DATA_LEN / SLICE_LEN;
  localparam int IDX_W      = idx_width(NUM_SLICES);

  if (DATA_LEN % SLICE_LEN != 0) begin : g_len_check
    $error("wide_add_seq: DATA_LEN must be an integer multiple of SLICE_LEN");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [DATA_LEN-1:0] a_q, a_d;
  logic [DATA_LEN-1:0] b_q, b_d;
  logic [DATA_LEN-1:0] result_q, result_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [SLICE_LEN-1:0] slice_a;
  logic [SLICE_LEN-1:0] slice_b;
  logic [SLICE_LEN-1:0] slice_sum;
  logic                 slice_cout;
  logic                 slice_ovf;
  logic                 last_slice;

  assign slice_a    = a_q[idx_q*SLICE_LEN +: SLICE_LEN];
  assign slice_b    = b_q[idx_q*SLICE_LEN +: SLICE_LEN];
  assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));

  adder_p #(.DATA_LEN(SLICE_LEN)) u_slice_add (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_q),
    .cout     (slice_cout),
    .sum      (slice_sum),
    .overflow (slice_ovf)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1, so invert B and force the carry-in here.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d[idx_q*SLICE_LEN +: SLICE_LEN] = slice_sum;
        carry_d = slice_cout;
        if (last_slice) begin
          // Only the top slice's carry and overflow describe the full word.
          cout_d  = slice_cout;
          ovf_d   = slice_ovf;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_sum      = result_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with DATA_LEN=32, SLICE_LEN=8.
// Latency: expects out_valid exactly 4 cycles after the accept edge.
// Backpressure: exercises out_ready hold in DONE and mid-operation reset.
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_overflow;

  wide_add_seq #(.DATA_LEN(32), .SLICE_LEN(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks latency on each rising out_valid and pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got sum 0x%08h with no pending op (cycle %0d)", out_sum, cyc);
        end else begin
          chk("latency", 32'(cyc - sb[0].acc), 32'd4);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_sum", out_sum, mon_e.sum);
        chk1("out_cout", out_cout, mon_e.cout);
        chk1("out_overflow", out_overflow, mon_e.ovf);
      end
      prev_vld = out_valid;
    end
  end

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input logic [31:0] es, input logic ec,
                      input logic eo, input bit push);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
      return;
    end
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) sb.push_back('{es, ec, eo, cyc});
    // Scramble operands after accept; they must have no further effect.
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'($urandom);
    in_sub   = 1'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk1("rst_out_cout", out_cout, 1'b0);
    chk1("rst_out_overflow", out_overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    // Basic add, then back-to-back full ripple to measure throughput.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    p = last_acc;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    chk("throughput", 32'(last_acc - p), 32'd6);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    // Subtracts with in_cin=1, which must be ignored.
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: hold DONE while a new request is offered.
    out_ready = 1'b0;
    send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b1);
    in_a     = 32'h1000_0000;
    in_b     = 32'h0000_0001;
    in_cin   = 1'b1;
    in_sub   = 1'b1;
    in_valid = 1'b1;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_sum", out_sum, 32'h0000_00FF);
      chk1("bp_out_cout", out_cout, 1'b0);
      chk1("bp_out_overflow", out_overflow, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_release_in_ready", in_ready, 1'b1);
    chk1("bp_release_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    sb.push_back('{32'h0FFF_FFFF, 1'b1, 1'b0, cyc});
    in_valid = 1'b0;
    chk1("bp_new_accepted", in_ready, 1'b0);
    drain();

    // Reset two cycles into RUN: partial result must vanish immediately.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_sum", out_sum, 32'h0);
    chk1("mid_rst_out_cout", out_cout, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs a DATA_LEN-bit add or subtract using one SLICE_LEN-bit adder_p slice.
- Processes one slice per cycle, least significant first, and forwards each slice's cout into the next slice's cin.
- Sits between a valid/ready requester and a valid/ready consumer.
- Trades latency for area where a full-width adder is not wanted.

Parameters:
- DATA_LEN, 32, total operand/result width; must be an integer multiple of SLICE_LEN.
- SLICE_LEN, 8, width of the instantiated adder_p slice.
- NUM_SLICES, DATA_LEN/SLICE_LEN, derived; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  DATA_LEN  operand A.
- in_b  input  DATA_LEN  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  1 = A - B, 0 = A + B + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  DATA_LEN  result.
- out_cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- out_overflow  output  1  two's-complement overflow of the full DATA_LEN result.

Behaviour:
- Reset (async assert, sync deassert via clk):
  - state=IDLE; slice index, carry, operand and result registers all 0.
  - out_valid=0, out_sum=0, out_cout=0, out_overflow=0; in_ready=1 after reset is released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture a_q=in_a, b_q=(in_sub ? ~in_b : in_b), carry_q=(in_sub ? 1 : in_cin), idx=0, then go to RUN.
- RUN:
  - in_ready=0.
  - adder_p is fed slice idx of a_q and b_q, with cin=carry_q.
  - Each cycle: write the slice sum into result bits [idx*SLICE_LEN +: SLICE_LEN], set carry_q=cout, idx++.
  - When idx==NUM_SLICES-1: register out_cout=cout and out_overflow=adder_p overflow (top slice only), then go to DONE.
- DONE:
  - out_valid=1; out_sum, out_cout and out_overflow are held stable.
  - On out_ready: go to IDLE and drop out_valid next cycle.
  - No accept in the same cycle as the handoff.
- Timing:
  - Latency is exactly NUM_SLICES cycles: the accept edge is cycle 0, and out_valid rises after the NUM_SLICES-th RUN edge.
  - Throughput is one operation per NUM_SLICES+2 cycles when out_ready is held high.
- Backpressure: in DONE with out_ready=0, hold everything indefinitely. in_valid is ignored there and in RUN.
- Stable inputs: in_a, in_b, in_cin and in_sub only need to be stable in the accept cycle; later changes have no effect.
- Reset mid-operation: abort immediately, apply the reset values, and do not emit a partial result.
- Out-of-range index: idx never exceeds NUM_SLICES-1; the width is $clog2(NUM_SLICES), minimum 1.
- Elaboration error: raised if DATA_LEN % SLICE_LEN != 0.

Decomposition:
- Shared package wide_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - SLICE_LEN default constant.
- Sub-module: one existing adder_p #(.DATA_LEN(SLICE_LEN)), ports a, b, cin, cout, sum, overflow.
- The FSM, index counter and result shift/write logic stay in wide_add_seq.

Test Plan (DATA_LEN=32, SLICE_LEN=8):
- Basic add: 0x000000FF + 0x00000001, cin=0, add -> out_sum=0x00000100, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: 0xFFFFFFFF + 0x00000001 -> out_sum=0x00000000, cout=1, overflow=0. A second op 0x00000000 + 0x00000000 with cin=1 -> out_sum=0x00000001.
- Signed overflow: 0x7FFFFFFF + 0x00000001 -> out_sum=0x80000000, cout=0, overflow=1.
- Subtract:
  - 5 - 7 -> out_sum=0xFFFFFFFE, cout=0, overflow=0.
  - 0x80000000 - 1 -> out_sum=0x7FFFFFFF, cout=1, overflow=1.
  - in_cin=1 is ignored in both cases.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, no capture. Release -> IDLE, then the new op is accepted.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> out_valid=0, out_sum=0 immediately (async). After release, in_ready=1, and 0x12345678 + 0x11111111 -> 0x23456789.
